// File: rtl/mux8way_arbiter.sv
// mux8way_arbiter: 8-source arbiter feeding a single registered output slot.
// Build option: define MUX8WAY_ARBITER_RR_EN for round-robin arbitration;
// when it is undefined the lowest requesting index always wins.
module mux8way_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  req,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  input  logic [15:0] e,
  input  logic [15:0] f,
  input  logic [15:0] g,
  input  logic [15:0] h,
  output logic [7:0]  ack,
  output logic [15:0] out,
  output logic [2:0]  sel,
  output logic        valid,
  input  logic        ready
);

  localparam int unsigned N_SRC  = 8;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned DATA_W = 16;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_t;

  slot_state_t        state;
  logic               slot_free;
  logic               found;
  logic               grant;
  logic [IDX_W-1:0]   win;
  logic [DATA_W-1:0]  win_data;

`ifdef MUX8WAY_ARBITER_RR_EN
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   scan_idx;

  // Round-robin winner: first requester at or after ptr, wrapping mod 8.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    scan_idx = '0;
    for (int k = 0; k < N_SRC; k++) begin
      scan_idx = ptr + IDX_W'(k);
      if (!found && req[scan_idx]) begin
        found = 1'b1;
        win   = scan_idx;
      end
    end
  end
`else
  // Fixed priority winner: lowest requesting index.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (!found && req[k]) begin
        found = 1'b1;
        win   = IDX_W'(k);
      end
    end
  end
`endif

  assign valid = (state == FULL);

  // Slot can take a word when empty or when the current word leaves this edge.
  always_comb begin
    slot_free = !valid || ready;
    grant     = found && slot_free && !reset;
    ack       = grant ? (N_SRC'(1) << win) : '0;
  end

  // Winner data mux.
  always_comb begin
    win_data = '0;
    case (win)
      3'd0: win_data = a;
      3'd1: win_data = b;
      3'd2: win_data = c;
      3'd3: win_data = d;
      3'd4: win_data = e;
      3'd5: win_data = f;
      3'd6: win_data = g;
      3'd7: win_data = h;
      default: win_data = '0;
    endcase
  end

  // Slot state, output word/index and arbitration pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      out   <= '0;
      sel   <= '0;
`ifdef MUX8WAY_ARBITER_RR_EN
      ptr   <= '0;
`endif
    end else if (grant) begin
      state <= FULL;
      out   <= win_data;
      sel   <= win;
`ifdef MUX8WAY_ARBITER_RR_EN
      ptr   <= win + IDX_W'(1);
`endif
    end else if (valid && ready) begin
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_mux8way_arbiter.sv
// Directed testbench for mux8way_arbiter (either arbitration build).
module tb_mux8way_arbiter;

  logic        clk;
  logic        reset;
  logic [7:0]  req;
  logic [15:0] data [8];
  logic [7:0]  ack;
  logic [15:0] out;
  logic [2:0]  sel;
  logic        valid;
  logic        ready;

  int checks;
  int errors;

  mux8way_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .a     (data[0]),
    .b     (data[1]),
    .c     (data[2]),
    .d     (data[3]),
    .e     (data[4]),
    .f     (data[5]),
    .g     (data[6]),
    .h     (data[7]),
    .ack   (ack),
    .out   (out),
    .sel   (sel),
    .valid (valid),
    .ready (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 8'h00;
    ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 8'hFF;
    ready = 1'b1;
    #1;
    checks++;
    if (ack !== 8'h00) begin
      errors++;
      $display("FAIL reset_ack: got %h expected 00", ack);
    end
    tick();
    tick();
    reset = 1'b0;
    req   = 8'h00;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ack !== 8'h00) begin
        errors++;
        $display("FAIL idle_ack[%0d]: got %h expected 00", i, ack);
      end
      tick();
      checks++;
      if (valid !== 1'b0 || out !== 16'h0000 || sel !== 3'd0) begin
        errors++;
        $display("FAIL idle_state[%0d]: got valid=%b out=%h sel=%0d expected 0/0000/0",
                 i, valid, out, sel);
      end
    end
  endtask

  task automatic test_single();
    ready = 1'b1;
    req   = 8'h04;
    #1;
    checks++;
    if (ack !== 8'h04) begin
      errors++;
      $display("FAIL single_ack: got %h expected 04", ack);
    end
    tick();
    req = 8'h00;
    checks++;
    if (valid !== 1'b1 || out !== 16'h1234 || sel !== 3'd2) begin
      errors++;
      $display("FAIL single_out: got valid=%b out=%h sel=%0d expected 1/1234/2",
               valid, out, sel);
    end
    tick();
    checks++;
    if (valid !== 1'b0 || out !== 16'h1234) begin
      errors++;
      $display("FAIL single_drain: got valid=%b out=%h expected 0/1234", valid, out);
    end
  endtask

  task automatic test_all_req();
    logic [2:0] exp_sel;
    logic [7:0] exp_ack;
    do_reset();
    ready = 1'b1;
    req   = 8'hFF;
    for (int k = 0; k < 9; k++) begin
`ifdef MUX8WAY_ARBITER_RR_EN
      exp_sel = 3'(k % 8);
`else
      exp_sel = 3'd0;
`endif
      exp_ack = 8'(1) << exp_sel;
      #1;
      checks++;
      if (ack !== exp_ack) begin
        errors++;
        $display("FAIL all_ack[%0d]: got %h expected %h", k, ack, exp_ack);
      end
      tick();
      checks++;
      if (valid !== 1'b1 || sel !== exp_sel || out !== data[exp_sel]) begin
        errors++;
        $display("FAIL all_sel[%0d]: got valid=%b sel=%0d out=%h expected 1/%0d/%h",
                 k, valid, sel, out, exp_sel, data[exp_sel]);
      end
    end
    req = 8'h00;
    tick();
  endtask

  task automatic test_backpressure();
    ready = 1'b0;
    req   = 8'h01;
    #1;
    checks++;
    if (ack !== 8'h01) begin
      errors++;
      $display("FAIL bp_fill_ack: got %h expected 01", ack);
    end
    tick();
    req = 8'h10;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (ack !== 8'h00) begin
        errors++;
        $display("FAIL bp_hold_ack[%0d]: got %h expected 00", i, ack);
      end
      tick();
      checks++;
      if (valid !== 1'b1 || sel !== 3'd0 || out !== 16'hA0A0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got valid=%b sel=%0d out=%h expected 1/0/a0a0",
                 i, valid, sel, out);
      end
    end
    ready = 1'b1;
    #1;
    checks++;
    if (ack !== 8'h10) begin
      errors++;
      $display("FAIL bp_release_ack: got %h expected 10", ack);
    end
    tick();
    req = 8'h00;
    checks++;
    if (valid !== 1'b1 || sel !== 3'd4 || out !== 16'hE4E4) begin
      errors++;
      $display("FAIL bp_release: got valid=%b sel=%0d out=%h expected 1/4/e4e4",
               valid, sel, out);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_sel;
    do_reset();
    ready = 1'b1;
    req   = 8'h80;
    #1;
    checks++;
    if (ack !== 8'h80) begin
      errors++;
      $display("FAIL b2b_ack7: got %h expected 80", ack);
    end
    tick();
    req = 8'h81;
    checks++;
    if (sel !== 3'd7 || out !== 16'h7777) begin
      errors++;
      $display("FAIL b2b_sel7: got sel=%0d out=%h expected 7/7777", sel, out);
    end
    #1;
    checks++;
    if (ack !== 8'h01) begin
      errors++;
      $display("FAIL b2b_ack0: got %h expected 01", ack);
    end
    tick();
    checks++;
    if (valid !== 1'b1 || sel !== 3'd0 || out !== 16'hA0A0) begin
      errors++;
      $display("FAIL b2b_sel0: got valid=%b sel=%0d out=%h expected 1/0/a0a0",
               valid, sel, out);
    end
`ifdef MUX8WAY_ARBITER_RR_EN
    exp_sel = 3'd7;
`else
    exp_sel = 3'd0;
`endif
    tick();
    req = 8'h00;
    checks++;
    if (valid !== 1'b1 || sel !== exp_sel) begin
      errors++;
      $display("FAIL b2b_third: got valid=%b sel=%0d expected 1/%0d", valid, sel, exp_sel);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    ready = 1'b0;
    req   = 8'h02;
    tick();
    checks++;
    if (valid !== 1'b1 || sel !== 3'd1) begin
      errors++;
      $display("FAIL rm_fill: got valid=%b sel=%0d expected 1/1", valid, sel);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (ack !== 8'h00) begin
      errors++;
      $display("FAIL rm_ack: got %h expected 00", ack);
    end
    tick();
    checks++;
    if (valid !== 1'b0 || out !== 16'h0000 || sel !== 3'd0) begin
      errors++;
      $display("FAIL rm_cleared: got valid=%b out=%h sel=%0d expected 0/0000/0",
               valid, out, sel);
    end
    reset = 1'b0;
    ready = 1'b1;
    #1;
    checks++;
    if (ack !== 8'h02) begin
      errors++;
      $display("FAIL rm_regrant_ack: got %h expected 02", ack);
    end
    tick();
    req = 8'h00;
    checks++;
    if (valid !== 1'b1 || sel !== 3'd1 || out !== 16'hB1B1) begin
      errors++;
      $display("FAIL rm_regrant: got valid=%b sel=%0d out=%h expected 1/1/b1b1",
               valid, sel, out);
    end
    tick();
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    req     = 8'h00;
    ready   = 1'b0;
    data[0] = 16'hA0A0;
    data[1] = 16'hB1B1;
    data[2] = 16'h1234;
    data[3] = 16'hD3D3;
    data[4] = 16'hE4E4;
    data[5] = 16'hF5F5;
    data[6] = 16'h6666;
    data[7] = 16'h7777;
    tick();
    test_reset();
    test_single();
    test_all_req();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux8way_arbiter.md
MUX8WAY_ARBITER -- requirements
Module: mux8way_arbiter

Interface
REQ-001 Ports SHALL be, in order:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  8  per-source request; bit 0 = source a … bit 7 = source h.
- a, b, c, d, e, f, g, h  in  16 each  source data words, indices 0..7.
- ack  out  8  one-hot; ack[i]=1 in the cycle source i's word is captured.
- out  out  16  registered output word.
- sel  out  3  index (0..7) of the source that produced out.
- valid  out  1  out/sel hold an undelivered word.
- ready  in  1  sink accepts out/sel when valid=1 and ready=1 at a rising edge.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset; no asynchronous logic.

Function
REQ-003 The block SHALL hold one output slot plus a 3-bit round-robin pointer ptr.
REQ-004 Slot state SHALL be EMPTY (valid=0) or FULL (valid=1).
REQ-005 The slot SHALL be free in a cycle when valid=0, or when valid=1 and ready=1.
REQ-006 Winner selection SHALL scan indices ptr, ptr+1, … ptr+7 mod 8 and pick the first i with req[i]=1.
REQ-007 ack SHALL be combinational: ack[winner]=1 only when the slot is free, some req is set and reset=0; otherwise ack=0.
REQ-008 On a capture edge, out SHALL load the winner's data, sel SHALL load its index, valid SHALL become 1, and ptr SHALL become winner+1 mod 8 (7 wraps to 0).
REQ-009 On an edge with valid=1 and ready=1 and no capture, valid SHALL become 0; out and sel SHALL hold their values.
REQ-010 valid=1 and ready=0 SHALL hold out, sel and valid; ack SHALL be 0.
REQ-011 Delivery plus a new capture on the same edge SHALL load the new word and keep valid=1, giving a throughput of one word per cycle.
REQ-012 Latency SHALL be one cycle: req[i] sampled with a free slot at edge N gives valid=1 with out=data[i] after edge N.
REQ-013 Sources SHALL hold req and data stable until ack; a source that keeps req high after ack SHALL be treated as a new request.
REQ-014 With req=0, ack SHALL be 0 and ptr SHALL hold.
REQ-015 With all 8 requests held high and ready=1, grant order SHALL be 0,1,…,7,0 with no gaps.

Reset
REQ-016 While reset=1 at an edge, the block SHALL set valid=0, out=16'h0000, sel=3'd0 and ptr=3'd0.
REQ-017 While reset=1, ack SHALL be 0.
REQ-018 Reset mid-transfer SHALL discard any pending word without delivery.
REQ-019 The first capture after reset SHALL occur at the first edge with reset=0.

Configuration
REQ-020 Macro MUX8WAY_ARBITER_RR_EN SHALL select the arbitration policy.
- Defined: round-robin per REQ-006/REQ-008.
- Undefined: fixed priority; the lowest set index wins; ptr is absent or held at 0.
- Ports and timing are identical in both builds.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset, then req=8'h00 for 3 cycles -> valid=0, ack=0, out=0, sel=0.
- req=8'h04, c=16'h1234, ready=1 -> ack=8'h04 that cycle; next cycle valid=1, out=16'h1234, sel=2.
- req=8'hFF held, ready=1, RR build -> sel sequence 0,1,2,3,4,5,6,7,0 on consecutive cycles. Fixed-priority build -> sel=0 every cycle.
- FULL with ready=0 for 4 cycles, req=8'h10 -> ack=0 throughout, out/sel unchanged. Raise ready -> ack=8'h10 in that cycle, sel=4 next cycle.
- Back-to-back: capture from index 7, then req=8'h81 -> next grant is index 0 (ptr wrapped), then index 7.
- reset=1 while valid=1 and req=8'h02 -> ack=0; next cycle valid=0, out=0, sel=0. After release, req=8'h02 -> sel=1.
